// File: rtl/psr_icc_unit.sv
// psr_icc_unit: processor state register (icc, PIL, S, PS, ET, CWP) and
// window invalid mask, fed by the ALU flags. Also evaluates the Bicc
// conditions and returns the registered carry to the ALU.
// Optional macro PSR_ICC_BYPASS_EN: forward n_in..c_in straight to
// cond_true/carry_out in the cycle icc_we is asserted.
module psr_icc_unit #(
  parameter int unsigned NWINDOWS = 8,
  parameter logic [7:0]  IMPL_VER = 8'h00
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                icc_we,
  input  logic                n_in,
  input  logic                z_in,
  input  logic                v_in,
  input  logic                c_in,
  input  logic                save,
  input  logic                restore,
  input  logic                trap_take,
  input  logic                rett,
  input  logic                wrpsr_we,
  input  logic [31:0]         wrpsr_data,
  input  logic                wrwim_we,
  input  logic [NWINDOWS-1:0] wrwim_data,
  input  logic [3:0]          cond,
  output logic [31:0]         psr_out,
  output logic [NWINDOWS-1:0] wim_out,
  output logic [4:0]          cwp_out,
  output logic                carry_out,
  output logic                cond_true,
  output logic                win_overflow,
  output logic                win_underflow,
  output logic                priv_err,
  output logic                error_mode
);

  localparam logic [4:0] CWP_MAX = 5'(NWINDOWS - 1);
  localparam logic [5:0] NWIN6   = 6'(NWINDOWS);

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_TRAP,
    ACT_RETT,
    ACT_WRPSR,
    ACT_SAVE,
    ACT_RESTORE
  } action_t;

  action_t             action;
  logic [3:0]          icc, icc_n;
  logic [3:0]          pil, pil_n;
  logic                s, s_n, ps, ps_n, et, et_n;
  logic [4:0]          cwp, cwp_n;
  logic [NWINDOWS-1:0] wim, wim_n;
  logic                em_n, ovf_n, unf_n, perr_n;
  logic [4:0]          cwp_dec, cwp_inc;
  logic [NWINDOWS-1:0] dec_sel, inc_sel;
  logic                dec_blocked, inc_blocked;
  logic                wrpsr_bad, wrpsr_ok;
  logic [3:0]          icc_eff;
  logic                base_true;
  logic                unused_wrpsr_bits;

  assign unused_wrpsr_bits = ^{wrpsr_data[31:24], wrpsr_data[19:12]};

  assign cwp_dec     = (cwp == 5'd0) ? CWP_MAX : cwp - 5'd1;
  assign cwp_inc     = (cwp == CWP_MAX) ? 5'd0 : cwp + 5'd1;
  assign dec_sel     = NWINDOWS'(1) << cwp_dec;
  assign inc_sel     = NWINDOWS'(1) << cwp_inc;
  assign dec_blocked = |(wim & dec_sel);
  assign inc_blocked = |(wim & inc_sel);
  assign wrpsr_bad   = !s || ({1'b0, wrpsr_data[4:0]} >= NWIN6);
  assign wrpsr_ok    = (action == ACT_WRPSR) && !wrpsr_bad;

  // Pick the single window/PSR action for this cycle by priority.
  always_comb begin
    action = ACT_NONE;
    if (trap_take)              action = ACT_TRAP;
    else if (rett)              action = ACT_RETT;
    else if (wrpsr_we)          action = ACT_WRPSR;
    else if (save && !restore)  action = ACT_SAVE;
    else if (restore && !save)  action = ACT_RESTORE;
  end

  // Next-state computation for PSR fields, WIM and the error pulses.
  always_comb begin
    icc_n  = icc;
    pil_n  = pil;
    s_n    = s;
    ps_n   = ps;
    et_n   = et;
    cwp_n  = cwp;
    wim_n  = wim;
    em_n   = error_mode;
    ovf_n  = 1'b0;
    unf_n  = 1'b0;
    perr_n = 1'b0;

    unique case (action)
      ACT_TRAP: begin
        if (!et) begin
          em_n = 1'b1;
        end else begin
          cwp_n = cwp_dec;
          ps_n  = s;
          s_n   = 1'b1;
          et_n  = 1'b0;
        end
      end
      ACT_RETT: begin
        if (et || !s) begin
          perr_n = 1'b1;
        end else if (inc_blocked) begin
          unf_n = 1'b1;
        end else begin
          cwp_n = cwp_inc;
          s_n   = ps;
          et_n  = 1'b1;
        end
      end
      ACT_WRPSR: begin
        if (wrpsr_bad) begin
          perr_n = 1'b1;
        end else begin
          pil_n = wrpsr_data[11:8];
          s_n   = wrpsr_data[7];
          ps_n  = wrpsr_data[6];
          et_n  = wrpsr_data[5];
          cwp_n = wrpsr_data[4:0];
        end
      end
      ACT_SAVE: begin
        if (dec_blocked) ovf_n = 1'b1;
        else             cwp_n = cwp_dec;
      end
      ACT_RESTORE: begin
        if (inc_blocked) unf_n = 1'b1;
        else             cwp_n = cwp_inc;
      end
      default: ;
    endcase

    // An accepted WRPSR owns icc; otherwise the ALU flags load independently.
    if (wrpsr_ok)    icc_n = wrpsr_data[23:20];
    else if (icc_we) icc_n = {n_in, z_in, v_in, c_in};

    if (wrwim_we) wim_n = wrwim_data;
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      icc           <= '0;
      pil           <= '0;
      s             <= 1'b1;
      ps            <= 1'b0;
      et            <= 1'b0;
      cwp           <= '0;
      wim           <= '0;
      error_mode    <= 1'b0;
      win_overflow  <= 1'b0;
      win_underflow <= 1'b0;
      priv_err      <= 1'b0;
    end else begin
      icc           <= icc_n;
      pil           <= pil_n;
      s             <= s_n;
      ps            <= ps_n;
      et            <= et_n;
      cwp           <= cwp_n;
      wim           <= wim_n;
      error_mode    <= em_n;
      win_overflow  <= ovf_n;
      win_underflow <= unf_n;
      priv_err      <= perr_n;
    end
  end

`ifdef PSR_ICC_BYPASS_EN
  assign icc_eff = (icc_we && !wrpsr_ok) ? {n_in, z_in, v_in, c_in} : icc;
`else
  assign icc_eff = icc;
`endif

  // Bicc condition evaluation; cond[3] inverts the base test.
  always_comb begin
    base_true = 1'b0;
    unique case (cond[2:0])
      3'd0: base_true = 1'b0;
      3'd1: base_true = icc_eff[2];
      3'd2: base_true = icc_eff[2] | (icc_eff[3] ^ icc_eff[1]);
      3'd3: base_true = icc_eff[3] ^ icc_eff[1];
      3'd4: base_true = icc_eff[0] | icc_eff[2];
      3'd5: base_true = icc_eff[0];
      3'd6: base_true = icc_eff[3];
      3'd7: base_true = icc_eff[1];
      default: base_true = 1'b0;
    endcase
  end

  assign cond_true = cond[3] ^ base_true;
  assign carry_out = icc_eff[0];
  assign psr_out   = {IMPL_VER, icc, 8'h00, pil, s, ps, et, cwp};
  assign wim_out   = wim;
  assign cwp_out   = cwp;

endmodule

// File: tb/tb_psr_icc_unit.sv
// Scoreboard bench for psr_icc_unit: directed scenarios then random traffic,
// all checked against a field-level reference model of the PSR/WIM rules.
module tb_psr_icc_unit;

  localparam int NW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          icc_we = 1'b0, n_in = 1'b0, z_in = 1'b0, v_in = 1'b0, c_in = 1'b0;
  logic          save = 1'b0, restore = 1'b0, trap_take = 1'b0, rett = 1'b0;
  logic          wrpsr_we = 1'b0;
  logic [31:0]   wrpsr_data = '0;
  logic          wrwim_we = 1'b0;
  logic [NW-1:0] wrwim_data = '0;
  logic [3:0]    cond = '0;
  logic [31:0]   psr_out;
  logic [NW-1:0] wim_out;
  logic [4:0]    cwp_out;
  logic          carry_out, cond_true, win_overflow, win_underflow, priv_err, error_mode;

  psr_icc_unit #(.NWINDOWS(NW), .IMPL_VER(8'h00)) dut (
    .clk(clk), .reset(reset), .icc_we(icc_we),
    .n_in(n_in), .z_in(z_in), .v_in(v_in), .c_in(c_in),
    .save(save), .restore(restore), .trap_take(trap_take), .rett(rett),
    .wrpsr_we(wrpsr_we), .wrpsr_data(wrpsr_data),
    .wrwim_we(wrwim_we), .wrwim_data(wrwim_data), .cond(cond),
    .psr_out(psr_out), .wim_out(wim_out), .cwp_out(cwp_out),
    .carry_out(carry_out), .cond_true(cond_true),
    .win_overflow(win_overflow), .win_underflow(win_underflow),
    .priv_err(priv_err), .error_mode(error_mode)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          reset, icc_we, n, z, v, c;
    logic          save, restore, trap_take, rett, wrpsr_we;
    logic [31:0]   wrpsr_data;
    logic          wrwim_we;
    logic [NW-1:0] wrwim_data;
    logic [3:0]    cond;
  } stim_t;

  typedef struct {
    logic [31:0]   psr;
    logic [NW-1:0] wim;
    logic [4:0]    cwp;
    logic          carry, ct, ovf, unf, perr, em;
    int            id;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   step_id = 0;

  // Reference model state
  bit       m_n, m_z, m_v, m_c;
  bit [3:0] m_pil;
  bit       m_s, m_ps, m_et, m_em;
  int       m_cwp;
  bit [NW-1:0] m_wim;

  function automatic bit eval_cond(input bit [3:0] cd, input bit n, input bit z,
                                   input bit v, input bit c);
    bit lt, le;
    lt = (n != v);
    le = z || lt;
    case (cd)
      4'h0: return 0;      4'h8: return 1;
      4'h1: return z;      4'h9: return !z;
      4'h2: return le;     4'hA: return !le;
      4'h3: return lt;     4'hB: return !lt;
      4'h4: return c || z; 4'hC: return !(c || z);
      4'h5: return c;      4'hD: return !c;
      4'h6: return n;      4'hE: return !n;
      default: return (cd == 4'h7) ? v : !v;
    endcase
  endfunction

  function automatic stim_t idle();
    stim_t st;
    st.reset = 0; st.icc_we = 0; st.n = 0; st.z = 0; st.v = 0; st.c = 0;
    st.save = 0; st.restore = 0; st.trap_take = 0; st.rett = 0;
    st.wrpsr_we = 0; st.wrpsr_data = '0; st.wrwim_we = 0; st.wrwim_data = '0;
    st.cond = '0;
    return st;
  endfunction

  task automatic check(input string nm, input int id, input logic [31:0] act,
                       input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s step %0d: got %h expected %h", nm, id, act, expv);
  endtask

  // Apply one cycle of stimulus, advance the model, queue the expected outcome.
  task automatic step(input stim_t st);
    exp_t e;
    bit ovf, unf, perr, wr_ok, bypass;
    int up, dn, fld;
    bit fn, fz, fv, fc;
    @(negedge clk);
    reset = st.reset; icc_we = st.icc_we;
    n_in = st.n; z_in = st.z; v_in = st.v; c_in = st.c;
    save = st.save; restore = st.restore; trap_take = st.trap_take; rett = st.rett;
    wrpsr_we = st.wrpsr_we; wrpsr_data = st.wrpsr_data;
    wrwim_we = st.wrwim_we; wrwim_data = st.wrwim_data; cond = st.cond;

    ovf = 0; unf = 0; perr = 0; wr_ok = 0;
    fld = int'(st.wrpsr_data[4:0]);
    if (st.reset) begin
      {m_n, m_z, m_v, m_c} = 4'b0000;
      m_pil = 0; m_s = 1; m_ps = 0; m_et = 0; m_cwp = 0; m_wim = '0; m_em = 0;
    end else begin
      up = (m_cwp + 1) % NW;
      dn = (m_cwp + NW - 1) % NW;
      if (st.trap_take) begin
        if (!m_et) m_em = 1;
        else begin m_cwp = dn; m_ps = m_s; m_s = 1; m_et = 0; end
      end else if (st.rett) begin
        if (m_et || !m_s) perr = 1;
        else if (m_wim[up]) unf = 1;
        else begin m_cwp = up; m_s = m_ps; m_et = 1; end
      end else if (st.wrpsr_we) begin
        if (!m_s || fld >= NW) perr = 1;
        else begin
          wr_ok = 1;
          {m_n, m_z, m_v, m_c} = st.wrpsr_data[23:20];
          m_pil = st.wrpsr_data[11:8];
          m_s = st.wrpsr_data[7]; m_ps = st.wrpsr_data[6]; m_et = st.wrpsr_data[5];
          m_cwp = fld;
        end
      end else if (st.save && !st.restore) begin
        if (m_wim[dn]) ovf = 1; else m_cwp = dn;
      end else if (st.restore && !st.save) begin
        if (m_wim[up]) unf = 1; else m_cwp = up;
      end
      if (st.icc_we && !wr_ok) {m_n, m_z, m_v, m_c} = {st.n, st.z, st.v, st.c};
      if (st.wrwim_we) m_wim = st.wrwim_data;
    end

    // Outputs are sampled after the edge while this cycle's inputs are still held.
    {fn, fz, fv, fc} = {m_n, m_z, m_v, m_c};
`ifdef PSR_ICC_BYPASS_EN
    bypass = st.icc_we && !(st.wrpsr_we && !st.trap_take && !st.rett && m_s && fld < NW);
    if (bypass) {fn, fz, fv, fc} = {st.n, st.z, st.v, st.c};
`else
    bypass = 0;
`endif
    e.psr   = {8'h00, m_n, m_z, m_v, m_c, 8'h00, m_pil, m_s, m_ps, m_et, 5'(m_cwp)};
    e.wim   = m_wim;
    e.cwp   = 5'(m_cwp);
    e.carry = fc;
    e.ct    = eval_cond(st.cond, fn, fz, fv, fc);
    e.ovf   = ovf; e.unf = unf; e.perr = perr; e.em = m_em;
    e.id    = step_id;
    step_id++;
    sb.push_back(e);
  endtask

  // Monitor: every clock the DUT presents a new state; compare with the queue head.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("psr_out",       e.id, psr_out,                e.psr);
      check("wim_out",       e.id, 32'(wim_out),           32'(e.wim));
      check("cwp_out",       e.id, 32'(cwp_out),           32'(e.cwp));
      check("carry_out",     e.id, 32'(carry_out),         32'(e.carry));
      check("cond_true",     e.id, 32'(cond_true),         32'(e.ct));
      check("win_overflow",  e.id, 32'(win_overflow),      32'(e.ovf));
      check("win_underflow", e.id, 32'(win_underflow),     32'(e.unf));
      check("priv_err",      e.id, 32'(priv_err),          32'(e.perr));
      check("error_mode",    e.id, 32'(error_mode),        32'(e.em));
    end
  end

  initial begin
    stim_t st;
    // Reset state
    st = idle(); st.reset = 1; step(st); step(st);
    // Flag capture and the full condition sweep
    st = idle(); st.icc_we = 1; {st.n, st.z, st.v, st.c} = 4'b0101; step(st);
    for (int i = 0; i < 16; i++) begin st = idle(); st.cond = 4'(i); step(st); end
    // Window wrap and overflow
    st = idle(); st.wrwim_we = 1; st.wrwim_data = 8'h40; step(st);
    for (int i = 0; i < 3; i++) begin st = idle(); st.save = 1; step(st); end
    st = idle(); st.wrwim_we = 1; st.wrwim_data = 8'h10; step(st);
    st = idle(); st.save = 1; step(st);
    st = idle(); st.restore = 1; step(st);
    st = idle(); st.save = 1; st.restore = 1; step(st);
    // Trap entry and return
    st = idle(); st.wrpsr_we = 1; st.wrpsr_data = 32'h0000_0023; step(st);
    st = idle(); st.trap_take = 1; step(st);
    st = idle(); st.rett = 1; step(st);
    st = idle(); st.rett = 1; step(st);
    // Illegal CWP field in WRPSR
    st = idle(); st.reset = 1; step(st);
    st = idle(); st.wrpsr_we = 1; st.wrpsr_data = 32'h00F0_0FA9; step(st);
    // Error mode is sticky until reset
    st = idle(); st.trap_take = 1; step(st);
    for (int i = 0; i < 3; i++) begin st = idle(); st.save = 1; step(st); end
    st = idle(); st.reset = 1; st.save = 1; st.trap_take = 1; step(st);
    // save + trap_take with ET=1, plus icc_we alongside the trap
    st = idle(); st.wrpsr_we = 1; st.wrpsr_data = 32'h0000_00A4; step(st);
    st = idle(); st.save = 1; st.trap_take = 1; st.icc_we = 1;
    {st.n, st.z, st.v, st.c} = 4'b1010; st.cond = 4'h6; step(st);
    // Accepted WRPSR beats icc_we
    st = idle(); st.wrpsr_we = 1; st.wrpsr_data = 32'h0090_0381; st.icc_we = 1;
    {st.n, st.z, st.v, st.c} = 4'b0110; st.cond = 4'h5; step(st);
    // Restore wrap from NWINDOWS-1 to 0
    st = idle(); st.wrpsr_we = 1; st.wrpsr_data = 32'h0000_0087; step(st);
    st = idle(); st.restore = 1; step(st);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      st = idle();
      st.reset      = ($urandom_range(0, 99) == 0);
      st.icc_we     = 1'($urandom_range(0, 1));
      {st.n, st.z, st.v, st.c} = 4'($urandom);
      st.save       = ($urandom_range(0, 3) == 0);
      st.restore    = ($urandom_range(0, 3) == 0);
      st.trap_take  = ($urandom_range(0, 9) == 0);
      st.rett       = ($urandom_range(0, 7) == 0);
      st.wrpsr_we   = ($urandom_range(0, 7) == 0);
      st.wrpsr_data = $urandom;
      st.wrpsr_data[4:0] = 5'($urandom_range(0, 9));
      st.wrpsr_data[7]   = ($urandom_range(0, 3) != 0);
      st.wrwim_we   = ($urandom_range(0, 7) == 0);
      st.wrwim_data = NW'($urandom & $urandom);
      st.cond       = 4'($urandom);
      step(st);
    end

    st = idle(); step(st);
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
